// File: rtl/cpu_run_ctrl.sv
`timescale 1ns/1ps
// cpu_run_ctrl
//   Sequences one run of a monitored CPU. A start request pulses the CPU
//   reset low for HOLD_CYCLES cycles. The CPU is then released and its output
//   bus is watched until one of two things happens:
//   - a halt condition is seen, which ends in DONE;
//   - MAX_CYCLES run cycles elapse, which ends in TIMEOUT.
//   When both occur on the same cycle, DONE wins.
//   There are two halt conditions, selected by HALT_MODE:
//   - mode 0: op equals the HALT_OP signature;
//   - mode 1: op stays unchanged for STABLE_CYCLES consecutive run cycles.
//
// Ports
//   clk          : single clock, rising-edge
//   reset        : asynchronous, active-high reset of this block
//   start        : one-cycle run request, honoured in IDLE / DONE / TIMEOUT
//   op           : CPU output bus being monitored
//   cpu_reset_n  : CPU reset, active-low (high only while running)
//   running      : high while in RUN
//   done         : high while in DONE
//   timeout      : high while in TIMEOUT
//   cycle_count  : RUN cycles of the current / last run
//   change_count : op value changes seen during RUN, saturating
//   last_op      : op sampled on the terminating RUN cycle
module cpu_run_ctrl #(
  parameter int                  OP_WIDTH      = 32,
  parameter int                  CNT_W         = 16,
  parameter int                  HOLD_CYCLES   = 4,
  parameter int                  MAX_CYCLES    = 1024,
  parameter int                  HALT_MODE     = 0,
  parameter logic [OP_WIDTH-1:0] HALT_OP       = '1,
  parameter int                  STABLE_CYCLES = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [OP_WIDTH-1:0] op,
  output logic                cpu_reset_n,
  output logic                running,
  output logic                done,
  output logic                timeout,
  output logic [CNT_W-1:0]    cycle_count,
  output logic [CNT_W-1:0]    change_count,
  output logic [OP_WIDTH-1:0] last_op
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HOLD,
    S_RUN,
    S_DONE,
    S_TIMEOUT
  } state_t;

  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] MAX_CNT    = CNT_W'(MAX_CYCLES);
  localparam logic [CNT_W-1:0] STABLE_CNT = CNT_W'(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] ONE        = CNT_W'(1);

  state_t              state;
  state_t              state_nxt;

  logic [CNT_W-1:0]    hold_cnt;
  logic [CNT_W-1:0]    stable_cnt;
  logic [OP_WIDTH-1:0] op_p0;

  logic                start_ok;
  logic                first_run;
  logic                op_changed;
  logic [CNT_W-1:0]    cyc_inc;
  logic [CNT_W-1:0]    stable_upd;
  logic                halt_hit;
  logic                limit_hit;
  logic                run_end;

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    logic [CNT_W-1:0] r;
    if (v == '1) begin
      r = v;
    end else begin
      r = v + ONE;
    end
    return r;
  endfunction

  // Run-cycle evaluation: change detection, stability window, halt and limit
  always_comb begin
    start_ok  = start && ((state == S_IDLE) || (state == S_DONE) ||
                          (state == S_TIMEOUT));
    // cycle_count is cleared on the way into HOLD, so zero marks the first
    // RUN cycle, which has no previous op to compare against.
    first_run  = (cycle_count == '0);
    op_changed = !first_run && (op != op_p0);
    cyc_inc    = cycle_count + ONE;

    if (first_run || op_changed) begin
      stable_upd = ONE;
    end else begin
      stable_upd = stable_cnt + ONE;
    end

    if (HALT_MODE == 0) begin
      halt_hit = (op == HALT_OP);
    end else begin
      halt_hit = (stable_upd == STABLE_CNT);
    end

    limit_hit = (cyc_inc == MAX_CNT);
    run_end   = (state == S_RUN) && (halt_hit || limit_hit);
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE, S_TIMEOUT: begin
        if (start_ok) begin
          state_nxt = S_HOLD;
        end
      end
      S_HOLD: begin
        if (hold_cnt == HOLD_LAST) begin
          state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        // Halt is checked first so it takes priority over the limit.
        if (halt_hit) begin
          state_nxt = S_DONE;
        end else if (limit_hit) begin
          state_nxt = S_TIMEOUT;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Registered status outputs, one-hot decoded from the upcoming state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cpu_reset_n <= 1'b0;
      running     <= 1'b0;
      done        <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      cpu_reset_n <= (state_nxt == S_RUN);
      running     <= (state_nxt == S_RUN);
      done        <= (state_nxt == S_DONE);
      timeout     <= (state_nxt == S_TIMEOUT);
    end
  end

  // Counters and op capture (_p0: op registered on each RUN cycle)
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_cnt     <= '0;
      stable_cnt   <= '0;
      cycle_count  <= '0;
      change_count <= '0;
      op_p0        <= '0;
      last_op      <= '0;
    end else begin
      if (start_ok) begin
        hold_cnt     <= '0;
        stable_cnt   <= '0;
        cycle_count  <= '0;
        change_count <= '0;
      end else if (state == S_HOLD) begin
        hold_cnt <= hold_cnt + ONE;
      end else if (state == S_RUN) begin
        cycle_count <= cyc_inc;
        stable_cnt  <= stable_upd;
        op_p0       <= op;
        if (op_changed) begin
          change_count <= sat_inc(change_count);
        end
        if (run_end) begin
          last_op <= op;
        end
      end
    end
  end

endmodule

// File: tb/tb_cpu_run_ctrl.sv
`timescale 1ns/1ps
// Self-checking bench for cpu_run_ctrl. Four instances with different
// configurations share clock, reset and op; each has its own start. Runs are
// executed one at a time, and each run's outcome is predicted from the op
// sequence alone:
//   - the first halt index, or the cycle limit;
//   - the number of value changes;
//   - the final op.
module tb_cpu_run_ctrl;

  localparam int NI = 4;

  logic                 clk;
  logic                 reset;
  logic [NI-1:0]        start_v;
  logic [31:0]          op;
  logic [NI-1:0]        crn_v;
  logic [NI-1:0]        run_v;
  logic [NI-1:0]        done_v;
  logic [NI-1:0]        to_v;
  logic [NI-1:0][15:0]  cyc_v;
  logic [NI-1:0][15:0]  chg_v;
  logic [NI-1:0][31:0]  lop_v;

  logic [31:0] ops [1:1100];

  int n_cmp;
  int n_err;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // 0: defaults; 1: short limit; 2: tiny limit, one hold cycle; 3: stability mode
  cpu_run_ctrl #(.OP_WIDTH(32), .CNT_W(16), .HOLD_CYCLES(4), .MAX_CYCLES(1024),
                 .HALT_MODE(0), .STABLE_CYCLES(8)) u_dut0 (
    .clk(clk), .reset(reset), .start(start_v[0]), .op(op),
    .cpu_reset_n(crn_v[0]), .running(run_v[0]), .done(done_v[0]),
    .timeout(to_v[0]), .cycle_count(cyc_v[0]), .change_count(chg_v[0]),
    .last_op(lop_v[0]));

  cpu_run_ctrl #(.OP_WIDTH(32), .CNT_W(16), .HOLD_CYCLES(4), .MAX_CYCLES(20),
                 .HALT_MODE(0), .STABLE_CYCLES(8)) u_dut1 (
    .clk(clk), .reset(reset), .start(start_v[1]), .op(op),
    .cpu_reset_n(crn_v[1]), .running(run_v[1]), .done(done_v[1]),
    .timeout(to_v[1]), .cycle_count(cyc_v[1]), .change_count(chg_v[1]),
    .last_op(lop_v[1]));

  cpu_run_ctrl #(.OP_WIDTH(32), .CNT_W(16), .HOLD_CYCLES(1), .MAX_CYCLES(10),
                 .HALT_MODE(0), .STABLE_CYCLES(8)) u_dut2 (
    .clk(clk), .reset(reset), .start(start_v[2]), .op(op),
    .cpu_reset_n(crn_v[2]), .running(run_v[2]), .done(done_v[2]),
    .timeout(to_v[2]), .cycle_count(cyc_v[2]), .change_count(chg_v[2]),
    .last_op(lop_v[2]));

  cpu_run_ctrl #(.OP_WIDTH(32), .CNT_W(16), .HOLD_CYCLES(3), .MAX_CYCLES(30),
                 .HALT_MODE(1), .STABLE_CYCLES(8)) u_dut3 (
    .clk(clk), .reset(reset), .start(start_v[3]), .op(op),
    .cpu_reset_n(crn_v[3]), .running(run_v[3]), .done(done_v[3]),
    .timeout(to_v[3]), .cycle_count(cyc_v[3]), .change_count(chg_v[3]),
    .last_op(lop_v[3]));

  function automatic int cfg_hold(input int i);
    case (i)
      0: return 4;
      1: return 4;
      2: return 1;
      default: return 3;
    endcase
  endfunction

  function automatic int cfg_max(input int i);
    case (i)
      0: return 1024;
      1: return 20;
      2: return 10;
      default: return 30;
    endcase
  endfunction

  function automatic int cfg_mode(input int i);
    return (i == 3) ? 1 : 0;
  endfunction

  function automatic int cfg_stable(input int i);
    return (i == 3) ? 8 : 8;
  endfunction

  task automatic check_val(input string tag, input logic [63:0] got,
                           input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Mode 0: the signature is on the bus.
  // Mode 1: the last S values, ending at k, are identical.
  function automatic bit halt_at(input int idx, input int k);
    int s;
    if (cfg_mode(idx) == 0) begin
      return ops[k] == 32'hFFFF_FFFF;
    end
    s = cfg_stable(idx);
    if (k < s) begin
      return 1'b0;
    end
    for (int j = k - s + 1; j < k; j++) begin
      if (ops[j] != ops[k]) begin
        return 1'b0;
      end
    end
    return 1'b1;
  endfunction

  task automatic predict(input int idx, output int end_k, output bit dn,
                         output int chg);
    end_k = cfg_max(idx);
    dn    = 1'b0;
    for (int k = 1; k <= cfg_max(idx); k++) begin
      if (halt_at(idx, k)) begin
        end_k = k;
        dn    = 1'b1;
        break;
      end
    end
    chg = 0;
    for (int i = 2; i <= end_k; i++) begin
      if (ops[i] != ops[i-1]) begin
        chg++;
      end
    end
  endtask

  task automatic check_reset_vals(input int idx);
    check_val("rst_crn", crn_v[idx], 0);
    check_val("rst_run", run_v[idx], 0);
    check_val("rst_done", done_v[idx], 0);
    check_val("rst_to", to_v[idx], 0);
    check_val("rst_cyc", cyc_v[idx], 0);
    check_val("rst_chg", chg_v[idx], 0);
    check_val("rst_lop", lop_v[idx], 0);
  endtask

  // One run on instance idx using ops[].
  // ign_at: RUN cycle at which a stray start is pulsed (0 = none).
  // abort_at: RUN cycle at which reset is asserted (0 = none).
  task automatic do_run(input int idx, input int ign_at, input int abort_at);
    int  end_k;
    bit  dn;
    int  chg;
    predict(idx, end_k, dn, chg);
    @(negedge clk);
    start_v[idx] = 1'b1;
    @(negedge clk);
    start_v[idx] = 1'b0;
    check_val("hold_done", done_v[idx], 0);
    check_val("hold_to", to_v[idx], 0);
    check_val("hold_cyc", cyc_v[idx], 0);
    check_val("hold_chg", chg_v[idx], 0);
    for (int h = 1; h <= cfg_hold(idx); h++) begin
      check_val("hold_crn", crn_v[idx], 0);
      check_val("hold_run", run_v[idx], 0);
      @(negedge clk);
    end
    for (int k = 1; k <= end_k; k++) begin
      op = ops[k];
      check_val("run_flag", run_v[idx], 1);
      check_val("run_crn", crn_v[idx], 1);
      check_val("run_cyc", cyc_v[idx], 64'(k - 1));
      start_v[idx] = (k == ign_at && k < end_k);
      if (k == abort_at) begin
        #2;
        reset = 1'b1;
        #1;
        check_reset_vals(idx);
        start_v[idx] = 1'b1;
        @(negedge clk);
        check_reset_vals(idx);
        reset = 1'b0;
        start_v[idx] = 1'b0;
        for (int w = 0; w < cfg_hold(idx) + 3; w++) begin
          @(negedge clk);
          check_val("idle_after_rst", run_v[idx], 0);
        end
        return;
      end
      @(negedge clk);
    end
    start_v[idx] = 1'b0;
    check_val("end_run", run_v[idx], 0);
    check_val("end_crn", crn_v[idx], 0);
    check_val("end_done", done_v[idx], 64'(dn));
    check_val("end_to", to_v[idx], dn ? 64'd0 : 64'd1);
    check_val("end_cyc", cyc_v[idx], 64'(end_k));
    check_val("end_chg", chg_v[idx], 64'(chg));
    check_val("end_lop", lop_v[idx], 64'(ops[end_k]));
    @(negedge clk);
    check_val("hold_cyc_after", cyc_v[idx], 64'(end_k));
  endtask

  task automatic gen_ops(input int idx);
    int mx;
    int kind;
    int pos;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] v;
    mx   = cfg_max(idx);
    kind = $urandom_range(0, 2);
    a    = $urandom & 32'h7FFF_FFFF;
    b    = $urandom & 32'h7FFF_FFFF;
    v    = 32'd0;
    for (int k = 1; k <= mx; k++) begin
      case (kind)
        0: ops[k] = (k % 2 == 1) ? a : b;
        1: ops[k] = $urandom & 32'h7FFF_FFFF;
        default: begin
          if (k == 1 || $urandom_range(0, 3) == 0) begin
            v = 32'($urandom_range(0, 3));
          end
          ops[k] = v;
        end
      endcase
    end
    if (cfg_mode(idx) == 0 && $urandom_range(0, 7) != 0) begin
      pos = $urandom_range(1, (mx < 40) ? mx : 40);
      ops[pos] = 32'hFFFF_FFFF;
    end
  endtask

  task automatic fill_ops(input logic [31:0] val);
    for (int k = 1; k <= 1100; k++) begin
      ops[k] = val;
    end
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "bench watchdog expired");
  end

  initial begin
    n_cmp   = 0;
    n_err   = 0;
    reset   = 1'b1;
    start_v = '0;
    op      = '0;
    #3;
    for (int i = 0; i < NI; i++) begin
      check_reset_vals(i);
    end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Halt signature on RUN cycle 10
    fill_ops(32'd0);
    ops[10] = 32'hFFFF_FFFF;
    do_run(0, 0, 0);
    check_val("r036_done", done_v[0], 1);
    check_val("r036_cyc", cyc_v[0], 10);
    check_val("r036_lop", lop_v[0], 64'hFFFF_FFFF);

    // Toggling op, never halts, limit 20
    for (int k = 1; k <= 1100; k++) begin
      ops[k] = (k % 2 == 1) ? 32'h5 : 32'hA;
    end
    do_run(1, 0, 0);
    check_val("r037_to", to_v[1], 1);
    check_val("r037_done", done_v[1], 0);
    check_val("r037_cyc", cyc_v[1], 20);
    check_val("r037_chg", chg_v[1], 19);

    // Stability halt: changes on cycles 2..5, then constant
    fill_ops(32'd5);
    ops[1] = 32'd0;
    for (int k = 2; k <= 5; k++) begin
      ops[k] = 32'(k);
    end
    do_run(3, 0, 0);
    check_val("r038_done", done_v[3], 1);
    check_val("r038_cyc", cyc_v[3], 12);
    check_val("r038_chg", chg_v[3], 4);

    // Halt and limit on the same cycle: DONE wins
    fill_ops(32'd0);
    ops[10] = 32'hFFFF_FFFF;
    do_run(2, 0, 0);
    check_val("r039_done", done_v[2], 1);
    check_val("r039_to", to_v[2], 0);

    // Reset on RUN cycle 5, then a fresh run
    fill_ops(32'd3);
    ops[20] = 32'hFFFF_FFFF;
    do_run(0, 0, 5);
    do_run(0, 0, 0);
    check_val("r040_cyc", cyc_v[0], 20);

    // Stray start in RUN is ignored; start in DONE restarts
    fill_ops(32'd7);
    ops[8] = 32'hFFFF_FFFF;
    do_run(0, 3, 0);
    check_val("r041_cyc", cyc_v[0], 8);
    do_run(0, 0, 0);

    for (int t = 0; t < 30; t++) begin
      int idx;
      idx = $urandom_range(0, NI - 1);
      gen_ops(idx);
      do_run(idx, ($urandom_range(0, 2) == 0) ? 2 : 0, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
